// File: rtl/oped_debug_trace.sv
// rtl/oped_debug_trace.sv - timestamped change-capture trace FIFO for the opedTop debug vector
module oped_debug_trace #(
    parameter int DEPTH = 16,
    parameter int TSW   = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [31:0]              debug_in,
    input  logic                     enable,
    input  logic [31:0]              mask,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TSW+31:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]     debug_q;
    logic [TSW-1:0]  ts;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TSW+31:0] mem [DEPTH];

    logic evt;
    logic pop;
    logic push;
    logic drop;

    // Pops are gated by enable so that the whole FIFO state holds still while capture is off.
    always_comb begin
        evt  = enable && (((debug_in ^ debug_q) & mask) != 32'd0);
        pop  = enable && rd_ready && (count != '0);
        push = evt && ((count != FULL) || pop);
        drop = evt && !push;
    end

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            debug_q <= '0;
        end else begin
            debug_q <= debug_in;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ts <= '0;
        end else if (clear) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Storage is not reset; only pointers and occupancy define what is valid.
    always_ff @(posedge CLK) begin
        if (push && !clear) begin
            mem[wr_ptr] <= {ts, debug_in};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_oped_debug_trace.sv
// tb/tb_oped_debug_trace.sv - self-checking bench for oped_debug_trace
module tb_oped_debug_trace;

    localparam int DEPTH = 16;
    localparam int TSW   = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] debug_in = '0;
    logic        enable = 1'b0;
    logic [31:0] mask = '0;
    logic        clear = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [TSW+31:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    oped_debug_trace #(.DEPTH(DEPTH), .TSW(TSW)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .debug_in(debug_in),
        .enable(enable),
        .mask(mask),
        .clear(clear),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .count(count),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    // Reference: a queue of {ts, value} entries plus the sticky drop state.
    logic [47:0] mq[$];
    logic [31:0] m_dq;
    logic [15:0] m_ts;
    logic [15:0] m_drops;
    logic        m_ovf;
    logic        m_ev;
    logic        m_pop;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mq.delete();
            m_dq = '0;
            m_ts = '0;
            m_drops = '0;
            m_ovf = 1'b0;
        end else begin
            m_ev  = enable && (((debug_in ^ m_dq) & mask) != 0);
            m_pop = enable && rd_ready && (mq.size() != 0);
            if (clear) begin
                mq.delete();
                m_ovf = 1'b0;
                m_drops = '0;
                m_ts = '0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_ev) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back({m_ts, debug_in});
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                    end
                end
                m_ts = m_ts + 16'd1;
            end
            m_dq = debug_in;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("model_rd_valid", rd_valid, mq.size() != 0);
            chk("model_count", count, mq.size());
            if (mq.size() != 0) chk("model_rd_data", rd_data, mq[0]);
            chk("model_overflow", overflow, m_ovf);
            chk("model_drop_count", drop_count, m_drops);
        end
    end

    task automatic cyc(input logic [31:0] d, input logic en, input logic rr, input logic clr);
        debug_in = d;
        enable   = en;
        rd_ready = rr;
        clear    = clr;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int n;
        mask = 32'hFFFF_FFFF;
        enable = 1'b1;
        debug_in = 32'h1;
        repeat (3) @(negedge CLK);
        chk("reset_count", count, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_drop_count", drop_count, 0);
        RST_N = 1'b1;

        // first post-reset event compares against debug_q=0 and takes ts=0
        cyc(32'h1, 1, 0, 0);
        cyc(32'h1, 1, 0, 0);
        chk("first_count", count, 1);
        chk("first_entry", rd_data, 48'h0000_0000_0001);

        // masked change ignored, qualified change stored
        mask = 32'h0000_00FF;
        cyc(32'h0, 1, 0, 1);
        cyc(32'h100, 1, 0, 0);
        cyc(32'h101, 1, 0, 0);
        chk("mask_count", count, 1);
        chk("mask_entry", rd_data, {16'h0001, 32'h0000_0101});

        // overflow: 20 events into 16 entries
        mask = 32'hFFFF_FFFF;
        cyc(32'h0, 1, 0, 1);
        for (int i = 1; i <= 20; i++) cyc(i, 1, 0, 0);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 4);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_read_order", rd_data[31:0], i + 1);
            cyc(32'd20, 1, 1, 0);
        end
        chk("ovf_drained", count, 0);
        chk("ovf_sticky", overflow, 1);

        // full FIFO accepts a write when popping in the same cycle
        cyc(32'h0, 1, 0, 1);
        for (int i = 1; i <= 16; i++) cyc(i, 1, 0, 0);
        chk("full_count", count, 16);
        cyc(32'd100, 1, 1, 0);
        chk("full_pushpop_count", count, 16);
        chk("full_pushpop_ovf", overflow, 0);
        chk("full_pushpop_head", rd_data[31:0], 2);

        // clear beats simultaneous event and pop
        cyc(32'h0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) cyc(i, 1, 0, 0);
        chk("clr_pre_count", count, 5);
        cyc(32'd6, 1, 1, 1);
        chk("clr_count", count, 0);
        chk("clr_rd_valid", rd_valid, 0);
        chk("clr_drops", drop_count, 0);
        cyc(32'd7, 1, 0, 0);
        chk("clr_ts_restart", rd_data, {16'h0000, 32'h7});

        // disabled: nothing captured, debug_q still tracks the input
        cyc(32'd8, 0, 0, 0);
        cyc(32'd9, 0, 0, 0);
        chk("dis_count", count, 1);
        cyc(32'd9, 1, 0, 0);
        chk("dis_dq_tracks", count, 1);

        // reset mid-operation discards entries
        cyc(32'd10, 1, 0, 0);
        chk("mid_pre_count", count, 2);
        debug_in = 32'h5;
        #2 RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", rd_valid, 0);
        RST_N = 1'b1;
        cyc(32'h5, 1, 0, 0);
        chk("mid_rst_entry", rd_data, {16'h0000, 32'h5});

        // timestamp wrap
        cyc(32'h5, 1, 1, 0);
        cyc(32'h5, 1, 0, 1);
        n = 0;
        while (m_ts != 16'hFFFF && n < 70000) begin
            cyc(32'h5, 1, 0, 0);
            n++;
        end
        chk("wrap_reached", n < 70000, 1);
        cyc(32'h6, 1, 0, 0);
        cyc(32'h7, 1, 0, 0);
        cyc(32'h8, 1, 0, 0);
        chk("wrap_count", count, 3);
        chk("wrap_ffff", rd_data, {16'hFFFF, 32'h6});
        cyc(32'h8, 1, 1, 0);
        chk("wrap_0000", rd_data, {16'h0000, 32'h7});
        cyc(32'h8, 1, 1, 0);
        chk("wrap_0001", rd_data, {16'h0001, 32'h8});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
